freq_meter: RTL and testbench

Frequency meter for slow square-wave signals, such as the 2 Hz and other divided ticks produced elsewhere in the design. It counts rising edges of `sig_in` over a fixed gate window of `GATE` clock cycles and publishes the result as four packed BCD digits for the LCD driver. A one-cycle `freq_valid` strobe accompanies each new result. An `overflow` flag is set when the count saturates.

---
 rtl/freq_meter_pkg.sv | 34 +++
 rtl/freq_meter_bcd_digit.sv | 27 ++
 rtl/freq_meter.sv | 103 ++++++++++
 tb/tb_freq_meter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants and a BCD helper for the gated-window edge counter.
// The closing-value helper lets the top report a same-cycle edge without waiting a clock.
package freq_meter_pkg;

  localparam int DIGIT_W      = 4;
  localparam int N_DIGITS     = 4;
  localparam int BCD_W        = DIGIT_W * N_DIGITS;
  localparam int GCNT_W       = 27;
  localparam int GATE_DEFAULT = 50000000;

  localparam logic [BCD_W-1:0] BCD_SAT = 16'h9999;

  // Packed-BCD increment that sticks at 9999 instead of wrapping.
  function automatic logic [BCD_W-1:0] bcd_inc_sat(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             c;
    r = v;
    c = 1'b1;
    if (v != BCD_SAT) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (c) begin
          if (r[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(9)) begin
            r[i*DIGIT_W +: DIGIT_W] = '0;
          end else begin
            r[i*DIGIT_W +: DIGIT_W] = r[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_meter_bcd_digit.sv
// One decimal digit of the edge counter; chained through carry to build a multi-digit BCD count.
module bcd_digit
  import freq_meter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic               hold,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  assign carry = inc && (q == DIGIT_W'(9));

  // Clear wins over increment so a window always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !hold) begin
      q <= (q == DIGIT_W'(9)) ? '0 : q + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Counts synchronized rising edges of sig_in over a GATE-cycle window and
// publishes the saturated BCD count with a one-cycle strobe.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE = GATE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [BCD_W-1:0] freq_bcd,
  output logic             freq_valid,
  output logic             overflow
);

  logic              s1, s2, s3;
  logic              rise;
  logic [GCNT_W-1:0] gcnt;
  logic              win_end;
  logic              armed;
  logic              sat;
  logic [N_DIGITS-1:0] inc;
  logic [N_DIGITS-1:0] carry;
  logic [BCD_W-1:0]  count;
  logic [BCD_W-1:0]  closing;
  logic              at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise    = s2 & ~s3;
  assign win_end = (gcnt == GCNT_W'(GATE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt <= '0;
    end else if (win_end) begin
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + GCNT_W'(1);
    end
  end

  assign at_max = (count == BCD_SAT);
  assign inc    = {carry[N_DIGITS-2:0], rise};

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (win_end),
      .inc   (inc[g]),
      .hold  (at_max),
      .q     (count[g*DIGIT_W +: DIGIT_W]),
      .carry (carry[g])
    );
  end

  // A full carry chain only happens on an edge arriving at 9999: that is saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat <= 1'b0;
    end else if (win_end) begin
      sat <= 1'b0;
    end else if (carry[N_DIGITS-1]) begin
      sat <= 1'b1;
    end
  end

  assign closing = rise ? bcd_inc_sat(count) : count;

  // freq_valid is a strobe with no back-pressure: freq_bcd/overflow are
  // valid and newly updated exactly in the cycle freq_valid is high, and
  // hold their value until the next strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed      <= 1'b0;
      freq_bcd   <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (win_end) begin
        armed <= 1'b1;
        if (armed) begin
          freq_bcd   <= closing;
          overflow   <= sat | carry[N_DIGITS-1];
          freq_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: three instances with different gate windows, checked
// against a model that counts rising transitions of the driven stimulus.
module tb_freq_meter;

  localparam int G0 = 100;
  localparam int G1 = 2000;
  localparam int G2 = 20000;

  logic        clk = 1'b0;
  logic [2:0]  rst_v = 3'b111;
  logic [2:0]  sig_v = 3'b000;
  logic [15:0] bcd [3];
  logic [2:0]  valid;
  logic [2:0]  ov;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  freq_meter #(.GATE(G0)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .sig_in(sig_v[0]),
    .freq_bcd(bcd[0]), .freq_valid(valid[0]), .overflow(ov[0])
  );
  freq_meter #(.GATE(G1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .sig_in(sig_v[1]),
    .freq_bcd(bcd[1]), .freq_valid(valid[1]), .overflow(ov[1])
  );
  freq_meter #(.GATE(G2)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .sig_in(sig_v[2]),
    .freq_bcd(bcd[2]), .freq_valid(valid[2]), .overflow(ov[2])
  );

  // ---------------- stimulus generators ----------------
  int   tick = 0;
  int   n_cyc [3];
  logic prev_sig [3];
  int   per [3];
  int   off [3];
  logic hold_lvl [3];
  bit   rnd [3];
  bit   free_run [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      n_cyc[i] = 0; prev_sig[i] = 1'b0; per[i] = 0; off[i] = 0;
      hold_lvl[i] = 1'b0; rnd[i] = 1'b0; free_run[i] = 1'b0;
    end
  end

  // Value driven after edge n is the one sampled at edge n+1.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int base;
      base = free_run[i] ? tick : n_cyc[i];
      if (rnd[i])           sig_v[i] = 1'($urandom_range(0, 1));
      else if (per[i] == 0) sig_v[i] = hold_lvl[i];
      else                  sig_v[i] = ((base + 1 + off[i]) % per[i]) < (per[i] / 2);
    end
  end

  // ---------------- reference model ----------------
  // A rising transition seen at edge k reaches the counter at edge k+2;
  // window w owns counter edges (w-1)*G+1 .. w*G.
  int rq0[$];
  int rq1[$];
  int rq2[$];

  always @(posedge clk) begin
    tick++;
    for (int i = 0; i < 3; i++) begin
      if (rst_v[i]) begin
        n_cyc[i] = 0;
        prev_sig[i] = 1'b0;
        case (i)
          0: rq0.delete();
          1: rq1.delete();
          default: rq2.delete();
        endcase
      end else begin
        n_cyc[i]++;
        if (sig_v[i] && !prev_sig[i]) begin
          case (i)
            0: rq0.push_back(n_cyc[i] + 2);
            1: rq1.push_back(n_cyc[i] + 2);
            default: rq2.push_back(n_cyc[i] + 2);
          endcase
        end
        prev_sig[i] = sig_v[i];
      end
    end
  end

  function automatic int gate_of(input int i);
    return (i == 0) ? G0 : (i == 1) ? G1 : G2;
  endfunction

  function automatic int window_count(input int i, input int w);
    int lo, hi, c;
    lo = (w - 1) * gate_of(i);
    hi = w * gate_of(i);
    c = 0;
    case (i)
      0: foreach (rq0[j]) if (rq0[j] > lo && rq0[j] <= hi) c++;
      1: foreach (rq1[j]) if (rq1[j] > lo && rq1[j] <= hi) c++;
      default: foreach (rq2[j]) if (rq2[j] > lo && rq2[j] <= hi) c++;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    int s;
    logic [15:0] r;
    s = (v > 9999) ? 9999 : v;
    r[15:12] = 4'(s / 1000);
    r[11:8]  = 4'((s / 100) % 10);
    r[7:4]   = 4'((s / 10) % 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int i);
    @(negedge clk);
    rst_v[i] = 1'b1;
    repeat (3) @(negedge clk);
    rst_v[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int budget, output bit got,
                            output logic [15:0] b, output logic o,
                            output int at, output bit chg);
    logic [15:0] b0;
    int c;
    got = 1'b0; b = '0; o = 1'b0; at = 0; chg = 1'b0; c = 0;
    b0 = bcd[i];
    while (!got && c < budget) begin
      @(negedge clk);
      c++;
      if (valid[i]) begin
        got = 1'b1; b = bcd[i]; o = ov[i]; at = n_cyc[i];
      end else if (bcd[i] !== b0) begin
        chg = 1'b1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_v = 3'b111;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bcd[i] !== 16'h0000) begin errors++; $display("FAIL reset_bcd[%0d]: got %h expected 0000", i, bcd[i]); end
      checks++;
      if (valid[i] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", i, valid[i]); end
      checks++;
      if (ov[i] !== 1'b0) begin errors++; $display("FAIL reset_ovf[%0d]: got %b expected 0", i, ov[i]); end
    end
  endtask

  task automatic test_basic();
    bit got, chg; logic [15:0] b; logic o; int at, cnt;
    free_run[0] = 1'b1; per[0] = 10; rnd[0] = 1'b0;
    repeat (25) @(negedge clk);
    rst_v[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_valid(0, 3 * G0, got, b, o, at, chg);
      checks++;
      if (!got) begin errors++; $display("FAIL basic_timeout: no freq_valid in %0d cycles", 3 * G0); end
      else begin
        cnt = window_count(0, at / G0);
        checks++;
        if (at !== (2 + k) * G0) begin errors++; $display("FAIL basic_time: valid at %0d expected %0d", at, (2 + k) * G0); end
        checks++;
        if (b !== to_bcd(cnt)) begin errors++; $display("FAIL basic_bcd: got %h expected %h", b, to_bcd(cnt)); end
        checks++;
        if (o !== (cnt > 9999)) begin errors++; $display("FAIL basic_ovf: got %b expected %b", o, cnt > 9999); end
        checks++;
        if (chg) begin errors++; $display("FAIL basic_hold: freq_bcd changed without freq_valid (got changed=1 expected 0)"); end
        @(negedge clk);
        checks++;
        if (valid[0] !== 1'b0) begin errors++; $display("FAIL basic_pulse: valid got %b expected 0 one cycle later", valid[0]); end
      end
    end
    free_run[0] = 1'b0;
  endtask

  task automatic test_held_high();
    bit got, chg; logic [15:0] b; logic o; int at, cnt;
    per[0] = 0; hold_lvl[0] = 1'b1; rnd[0] = 1'b0;
    do_reset(0);
    for (int k = 0; k < 2; k++) begin
      wait_valid(0, 3 * G0, got, b, o, at, chg);
      checks++;
      if (!got) begin errors++; $display("FAIL held_timeout: no freq_valid in %0d cycles", 3 * G0); end
      else begin
        cnt = window_count(0, at / G0);
        checks++;
        if (at !== (2 + k) * G0) begin errors++; $display("FAIL held_time: valid at %0d expected %0d", at, (2 + k) * G0); end
        checks++;
        if (b !== to_bcd(cnt)) begin errors++; $display("FAIL held_bcd: got %h expected %h", b, to_bcd(cnt)); end
      end
    end
    hold_lvl[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got, chg; logic [15:0] b; logic o; int at, cnt, guard;
    per[0] = 10; off[0] = 0;
    do_reset(0);
    wait_valid(0, 3 * G0, got, b, o, at, chg);
    checks++;
    if (!got) begin errors++; $display("FAIL mid_prestart: no freq_valid in %0d cycles", 3 * G0); end
    guard = 0;
    while (n_cyc[0] < 275 && guard < 4 * G0) begin @(negedge clk); guard++; end
    rst_v[0] = 1'b1;
    #1;
    checks++;
    if (bcd[0] !== 16'h0000) begin errors++; $display("FAIL mid_async_bcd: got %h expected 0000", bcd[0]); end
    checks++;
    if (valid[0] !== 1'b0 || ov[0] !== 1'b0) begin errors++; $display("FAIL mid_async_flags: valid=%b ovf=%b expected 0 0", valid[0], ov[0]); end
    @(negedge clk);
    rst_v[0] = 1'b0;
    wait_valid(0, 3 * G0, got, b, o, at, chg);
    checks++;
    if (!got) begin errors++; $display("FAIL mid_timeout: no freq_valid in %0d cycles", 3 * G0); end
    else begin
      cnt = window_count(0, at / G0);
      checks++;
      if (at !== 2 * G0) begin errors++; $display("FAIL mid_warmup: valid at %0d expected %0d", at, 2 * G0); end
      checks++;
      if (b !== to_bcd(cnt)) begin errors++; $display("FAIL mid_bcd: got %h expected %h", b, to_bcd(cnt)); end
    end
  endtask

  task automatic test_random();
    bit got, chg; logic [15:0] b; logic o; int at, cnt;
    per[0] = $urandom_range(2, 40); off[0] = $urandom_range(0, 99); rnd[0] = 1'b0;
    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) rnd[0] = 1'b1;
      wait_valid(0, 3 * G0, got, b, o, at, chg);
      checks++;
      if (!got) begin errors++; $display("FAIL random_timeout: no freq_valid in %0d cycles", 3 * G0); end
      else begin
        cnt = window_count(0, at / G0);
        checks++;
        if (at !== (2 + k) * G0) begin errors++; $display("FAIL random_time: valid at %0d expected %0d", at, (2 + k) * G0); end
        checks++;
        if (b !== to_bcd(cnt)) begin errors++; $display("FAIL random_bcd: per=%0d got %h expected %h", per[0], b, to_bcd(cnt)); end
      end
    end
    rnd[0] = 1'b0;
  endtask

  task automatic test_carry();
    bit got, chg; logic [15:0] b; logic o; int at, cnt;
    per[1] = 2; off[1] = 0;
    do_reset(1);
    wait_valid(1, 3 * G1, got, b, o, at, chg);
    checks++;
    if (!got) begin errors++; $display("FAIL carry_timeout: no freq_valid in %0d cycles", 3 * G1); end
    else begin
      cnt = window_count(1, at / G1);
      checks++;
      if (b !== to_bcd(cnt)) begin errors++; $display("FAIL carry_bcd: got %h expected %h", b, to_bcd(cnt)); end
      checks++;
      if (o !== (cnt > 9999)) begin errors++; $display("FAIL carry_ovf: got %b expected %b", o, cnt > 9999); end
    end
  endtask

  task automatic test_phase();
    bit got, chg; logic [15:0] b; logic o; int at, cnt;
    // Place rises so they reach the counter exactly on the window-end cycle.
    per[1] = 200; off[1] = 200 - ((G1 - 2) % 200);
    do_reset(1);
    for (int k = 0; k < 2; k++) begin
      wait_valid(1, 3 * G1, got, b, o, at, chg);
      checks++;
      if (!got) begin errors++; $display("FAIL phase_timeout: no freq_valid in %0d cycles", 3 * G1); end
      else begin
        cnt = window_count(1, at / G1);
        checks++;
        if (b !== to_bcd(cnt)) begin errors++; $display("FAIL phase_bcd: got %h expected %h", b, to_bcd(cnt)); end
      end
    end
    per[1] = 0;
  endtask

  task automatic test_saturation();
    bit got, chg; logic [15:0] b; logic o; int at, cnt;
    per[2] = 2; off[2] = 0;
    do_reset(2);
    for (int k = 0; k < 2; k++) begin
      wait_valid(2, 3 * G2, got, b, o, at, chg);
      checks++;
      if (!got) begin errors++; $display("FAIL sat_timeout: no freq_valid in %0d cycles", 3 * G2); end
      else begin
        cnt = window_count(2, at / G2);
        checks++;
        if (b !== to_bcd(cnt)) begin errors++; $display("FAIL sat_bcd: got %h expected %h", b, to_bcd(cnt)); end
        checks++;
        if (o !== (cnt > 9999)) begin errors++; $display("FAIL sat_ovf: got %b expected %b", o, cnt > 9999); end
      end
      per[2] = 4;
    end
    per[2] = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_high();
    test_reset_mid();
    test_random();
    test_carry();
    test_phase();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
